// File: rtl/multi_debouncer_if.sv
// rtl/multi_debouncer_if.sv - sample-enable, raw inputs and debounced outputs of the multi-channel debouncer
interface multi_debouncer_if #(
    parameter int CHANNELS = 2
);
    logic                clock_enable;
    logic [CHANNELS-1:0] in_signal;
    logic [CHANNELS-1:0] out_signal;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                any_event;

    modport master (
        output clock_enable,
        output in_signal,
        input  out_signal,
        input  rise,
        input  fall,
        input  any_event
    );

    modport slave (
        input  clock_enable,
        input  in_signal,
        output out_signal,
        output rise,
        output fall,
        output any_event
    );
endinterface

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - per-channel synchroniser plus enabled stability counter with rise/fall pulses
module multi_debouncer #(
    parameter int CHANNELS     = 2,
    parameter int STABLE_COUNT = 8,
    parameter int SYNC_STAGES  = 2,
    parameter bit INIT_LEVEL   = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    multi_debouncer_if.slave  bus
);
    localparam int                 CW       = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [CW-1:0]      LAST     = CW'(STABLE_COUNT - 1);
    localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL}};

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
    logic [CHANNELS-1:0][CW-1:0]          r_cnt;
    logic [CHANNELS-1:0]                  r_out;
    logic [CHANNELS-1:0]                  r_rise;
    logic [CHANNELS-1:0]                  r_fall;
    logic                                 r_any;

    logic [CHANNELS-1:0]                  w_synch;
    logic [CHANNELS-1:0][CW-1:0]          w_cnt_nxt;
    logic [CHANNELS-1:0]                  w_out_nxt;
    logic [CHANNELS-1:0]                  w_rise_nxt;
    logic [CHANNELS-1:0]                  w_fall_nxt;

    assign w_synch = r_sync[SYNC_STAGES-1];

    // Any return to the current level clears the count, even while the sample tick is low.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_out_nxt  = r_out;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_synch[i] == r_out[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (bus.clock_enable) begin
                if (r_cnt[i] == LAST) begin
                    w_out_nxt[i]  = w_synch[i];
                    w_cnt_nxt[i]  = '0;
                    w_rise_nxt[i] = w_synch[i];
                    w_fall_nxt[i] = ~w_synch[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{INIT_VEC}};
            r_cnt  <= '0;
            r_out  <= INIT_VEC;
            r_rise <= '0;
            r_fall <= '0;
            r_any  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.in_signal};
            r_cnt  <= w_cnt_nxt;
            r_out  <= w_out_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_any  <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign bus.out_signal = r_out;
    assign bus.rise       = r_rise;
    assign bus.fall       = r_fall;
    assign bus.any_event  = r_any;
endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - directed bench for multi_debouncer with STABLE_COUNT 8 and 1 instances
module tb_multi_debouncer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    multi_debouncer_if #(.CHANNELS(2)) bus_a ();
    multi_debouncer_if #(.CHANNELS(2)) bus_b ();

    multi_debouncer #(.CHANNELS(2), .STABLE_COUNT(8), .SYNC_STAGES(2), .INIT_LEVEL(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    multi_debouncer #(.CHANNELS(2), .STABLE_COUNT(1), .SYNC_STAGES(2), .INIT_LEVEL(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a new input, expect the old level for edges 0..8, the accept on edge 9, then clear pulses.
    task automatic step(input string tag, input logic [1:0] nin, input logic [1:0] prev,
                        input logic [1:0] nout, input logic [1:0] er, input logic [1:0] ef);
        bus_a.in_signal = nin;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk({tag, " hold"}, {bus_a.any_event, bus_a.rise, bus_a.fall, bus_a.out_signal},
                {1'b0, 2'b00, 2'b00, prev});
        end
        tick();
        chk({tag, " out"},  {30'd0, bus_a.out_signal}, {30'd0, nout});
        chk({tag, " rise"}, {30'd0, bus_a.rise}, {30'd0, er});
        chk({tag, " fall"}, {30'd0, bus_a.fall}, {30'd0, ef});
        chk({tag, " any"},  {31'd0, bus_a.any_event}, 32'd1);
        tick();
        chk({tag, " clr"}, {bus_a.any_event, bus_a.rise, bus_a.fall, bus_a.out_signal},
            {1'b0, 2'b00, 2'b00, nout});
    endtask

    initial begin
        bus_a.clock_enable = 1'b0;
        bus_a.in_signal    = 2'b00;
        bus_b.clock_enable = 1'b0;
        bus_b.in_signal    = 2'b11;

        // reset with inputs low: outputs held at idle-high
        tick(); tick(); tick();
        chk("reset state", {bus_a.any_event, bus_a.rise, bus_a.fall, bus_a.out_signal}, {1'b0, 2'b00, 2'b00, 2'b11});
        bus_a.in_signal = 2'b11;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("release quiet", {bus_a.any_event, bus_a.rise, bus_a.fall, bus_a.out_signal}, {1'b0, 2'b00, 2'b00, 2'b11});
        end

        bus_a.clock_enable = 1'b1;
        step("clean step ch0", 2'b10, 2'b11, 2'b10, 2'b00, 2'b01);

        // five-cycle glitch on channel 1 must not qualify
        bus_a.in_signal = 2'b00;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("glitch low", {bus_a.any_event, bus_a.out_signal}, {1'b0, 2'b10});
        end
        bus_a.in_signal = 2'b10;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("glitch back", {bus_a.any_event, bus_a.out_signal}, {1'b0, 2'b10});
        end
        step("long low ch1", 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
        step("dual rise", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00);
        step("dual fall", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        step("dual rise2", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00);

        // sample tick one cycle in four
        bus_a.in_signal    = 2'b10;
        bus_a.clock_enable = 1'b0;
        tick(); tick(); tick();
        chk("gate settle", {30'd0, bus_a.out_signal}, 32'd3);
        for (int n = 1; n <= 8; n++) begin
            bus_a.clock_enable = 1'b1;
            tick();
            if (n < 8) begin
                chk("gate pending", {bus_a.any_event, bus_a.out_signal}, {1'b0, 2'b11});
            end else begin
                chk("gate accept", {bus_a.any_event, bus_a.fall, bus_a.out_signal}, {1'b1, 2'b01, 2'b10});
            end
            bus_a.clock_enable = 1'b0;
            tick();
            chk("gate pulse one", {bus_a.any_event, bus_a.fall}, {1'b0, 2'b00});
            tick(); tick();
        end

        // mismatch held with enable low keeps its count
        bus_a.in_signal = 2'b11;
        tick(); tick(); tick();
        bus_a.clock_enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("pre hold", {30'd0, bus_a.out_signal}, 32'd2);
        end
        bus_a.clock_enable = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("hold idle", {bus_a.any_event, bus_a.out_signal}, {1'b0, 2'b10});
        end
        bus_a.clock_enable = 1'b1;
        tick();
        chk("resume 6", {30'd0, bus_a.out_signal}, 32'd2);
        tick();
        chk("resume 7", {30'd0, bus_a.out_signal}, 32'd2);
        tick();
        chk("resume accept", {bus_a.any_event, bus_a.rise, bus_a.out_signal}, {1'b1, 2'b01, 2'b11});
        tick();
        chk("resume clr", {bus_a.any_event, bus_a.rise}, {1'b0, 2'b00});

        // reset in the middle of a count
        step("pre reset fall", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        bus_a.in_signal = 2'b11;
        for (int k = 0; k < 7; k++) tick();
        chk("mid count", {30'd0, bus_a.out_signal}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset", {bus_a.any_event, bus_a.rise, bus_a.fall, bus_a.out_signal}, {1'b0, 2'b00, 2'b00, 2'b11});
        bus_a.in_signal = 2'b00;
        tick(); tick();
        rst_n = 1'b1;
        step("post reset full", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);

        // STABLE_COUNT=1 instance
        bus_b.clock_enable = 1'b1;
        bus_b.in_signal    = 2'b10;
        tick();
        chk("sc1 edge0", {bus_b.any_event, bus_b.out_signal}, {1'b0, 2'b11});
        tick();
        chk("sc1 edge1", {bus_b.any_event, bus_b.out_signal}, {1'b0, 2'b11});
        tick();
        chk("sc1 accept", {bus_b.any_event, bus_b.rise, bus_b.fall, bus_b.out_signal}, {1'b1, 2'b00, 2'b01, 2'b10});
        tick();
        chk("sc1 clr", {bus_b.any_event, bus_b.fall}, {1'b0, 2'b00});
        bus_b.clock_enable = 1'b0;
        bus_b.in_signal    = 2'b11;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("sc1 gated", {bus_b.any_event, bus_b.out_signal}, {1'b0, 2'b10});
        end
        bus_b.clock_enable = 1'b1;
        tick();
        chk("sc1 rise", {bus_b.any_event, bus_b.rise, bus_b.fall, bus_b.out_signal}, {1'b1, 2'b01, 2'b00, 2'b11});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
